// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Conditions raw push-button levels for the game logic. Each channel has a
//   2-flop synchronizer, a counter-based debounce FSM, one-cycle press and
//   release pulses, and auto-repeat pulses while the button is held.
//   Channels are fully independent.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   btn_raw      asynchronous raw button levels, 1 = pressed
//   btn_level    debounced level (1 while HELD or RELEASE_WAIT)
//   btn_press    1-cycle pulse on an accepted press
//   btn_release  1-cycle pulse on an accepted release
//   btn_scen     1-cycle enable: press pulse OR auto-repeat pulse
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int N_BTN         = 5,
  parameter int DB_CYCLES     = 1_000_000,
  parameter int CNT_W         = 20,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int RPT_W         = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_scen
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);
  localparam bit               RPT_EN    = (REPEAT_DELAY != 0);

  // Synchronizer flops; the FSM only ever looks at s2_q.
  logic [N_BTN-1:0] s1_q, s2_q;

  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];
  logic [RPT_W-1:0] rpt_q   [N_BTN];
  logic [RPT_W-1:0] rpt_d   [N_BTN];
  // phase bit: 0 = waiting for the first repeat, 1 = periodic repeats
  logic [N_BTN-1:0] phase_q, phase_d;

  logic [N_BTN-1:0] rpt_hit;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] scen_q, scen_d;

  // ---------------------------------------------------------------------------
  // State register (also holds the registered outputs)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      phase_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      scen_q    <= '0;
      // NOTE: the per-channel arrays are small register banks, not RAM, so
      // every entry is cleared explicitly by a loop.
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        rpt_q[i]   <= '0;
      end
    end else begin
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      phase_q   <= phase_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      scen_q    <= scen_d;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        rpt_q[i]   <= rpt_d[i];
      end
    end
  end

  // Repeat limit depends on whether the first repeat has been issued yet.
  always_comb begin
    rpt_hit = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rpt_hit[i] = (rpt_q[i] == (phase_q[i] ? RPT_NEXT : RPT_FIRST));
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default at the top of the block,
  // so no path through the case statement can infer a latch.
  always_comb begin
    phase_d = phase_q;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      rpt_d[i]   = rpt_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (s2_q[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!s2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
            rpt_d[i]   = '0;
            phase_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        HELD: begin
          if (!s2_q[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = CNT_W'(1);
          end else if (RPT_EN) begin
            if (rpt_hit[i]) begin
              rpt_d[i]   = '0;
              phase_d[i] = 1'b1;
            end else begin
              rpt_d[i] = rpt_q[i] + RPT_W'(1);
            end
          end
        end
        RELEASE_WAIT: begin
          // rpt_q/phase_q stay frozen so a bounce back to HELD resumes the cadence.
          if (s2_q[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic (values registered on the same edge as the state)
  // ---------------------------------------------------------------------------
  always_comb begin
    level_d   = '0;
    press_d   = '0;
    release_d = '0;
    scen_d    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      level_d[i]   = (state_d[i] == HELD) || (state_d[i] == RELEASE_WAIT);
      press_d[i]   = (state_q[i] == PRESS_WAIT) && s2_q[i] && (cnt_q[i] == DB_LAST);
      release_d[i] = (state_q[i] == RELEASE_WAIT) && !s2_q[i] && (cnt_q[i] == DB_LAST);
      // Press and repeat are mutually exclusive: repeat needs state HELD.
      scen_d[i]    = press_d[i] ||
                     (RPT_EN && (state_q[i] == HELD) && s2_q[i] && rpt_hit[i]);
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_scen    = scen_q;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Directed bench for button_conditioner with DB_CYCLES=4, REPEAT_DELAY=8,
//   REPEAT_PERIOD=3. Inputs change 1 ns after a rising edge; loop index e is
//   the edge the stimulus is set up for, outputs are sampled 1 ns after edge e.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int N_BTN = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level, btn_press, btn_release, btn_scen;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [N_BTN-1:0] e_lvl, e_prs, e_rel, e_scn;

  button_conditioner #(
    .N_BTN        (N_BTN),
    .DB_CYCLES    (4),
    .CNT_W        (3),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(3),
    .RPT_W        (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_scen   (btn_scen)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    btn_raw = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    btn_raw = '0;
    tick();
    vec_cnt++;
    if ({btn_level, btn_press, btn_release, btn_scen} !== 20'h0) begin
      miss_cnt++;
      $display("FAIL reset: got lvl=%b prs=%b rel=%b scn=%b, want all zero",
               btn_level, btn_press, btn_release, btn_scen);
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    do_reset();
    for (int e = 0; e < 10; e++) begin
      btn_raw = 5'b00001;
      tick();
      e_lvl = (e >= 5) ? 5'b00001 : 5'b00000;
      e_prs = (e == 5) ? 5'b00001 : 5'b00000;
      e_rel = '0;
      e_scn = e_prs;
      vec_cnt++;
      if ({btn_level, btn_press, btn_release, btn_scen} !== {e_lvl, e_prs, e_rel, e_scn}) begin
        miss_cnt++;
        $display("FAIL clean_press edge %0d: got lvl=%b prs=%b rel=%b scn=%b, want lvl=%b prs=%b rel=%b scn=%b",
                 e, btn_level, btn_press, btn_release, btn_scen, e_lvl, e_prs, e_rel, e_scn);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int e = 0; e < 15; e++) begin
      btn_raw = (e < 3) ? 5'b00010 : 5'b00000;
      tick();
      vec_cnt++;
      if ({btn_level, btn_press, btn_release, btn_scen} !== 20'h0) begin
        miss_cnt++;
        $display("FAIL glitch edge %0d: got lvl=%b prs=%b rel=%b scn=%b, want all zero",
                 e, btn_level, btn_press, btn_release, btn_scen);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int e = 0; e < 22; e++) begin
      // high 2, low 2, ... for 12 cycles, then steady high from edge 12
      btn_raw = ((e >= 12) || ((e / 2) % 2 == 0)) ? 5'b00100 : 5'b00000;
      tick();
      e_lvl = (e >= 17) ? 5'b00100 : 5'b00000;
      e_prs = (e == 17) ? 5'b00100 : 5'b00000;
      e_rel = '0;
      e_scn = e_prs;
      vec_cnt++;
      if ({btn_level, btn_press, btn_release, btn_scen} !== {e_lvl, e_prs, e_rel, e_scn}) begin
        miss_cnt++;
        $display("FAIL bounce edge %0d: got lvl=%b prs=%b rel=%b scn=%b, want lvl=%b prs=%b rel=%b scn=%b",
                 e, btn_level, btn_press, btn_release, btn_scen, e_lvl, e_prs, e_rel, e_scn);
      end
    end
  endtask

  task automatic test_hold_repeat();
    do_reset();
    for (int e = 0; e < 42; e++) begin
      btn_raw = (e < 30) ? 5'b01000 : 5'b00000;
      tick();
      // press at edge 5; repeats at 13, 16, ... while HELD (last at 31);
      // release accepted at edge 35
      e_lvl = ((e >= 5) && (e < 35)) ? 5'b01000 : 5'b00000;
      e_prs = (e == 5) ? 5'b01000 : 5'b00000;
      e_rel = (e == 35) ? 5'b01000 : 5'b00000;
      e_scn = ((e == 5) || ((e >= 13) && (e <= 31) && ((e - 13) % 3 == 0)))
              ? 5'b01000 : 5'b00000;
      vec_cnt++;
      if ({btn_level, btn_press, btn_release, btn_scen} !== {e_lvl, e_prs, e_rel, e_scn}) begin
        miss_cnt++;
        $display("FAIL hold_repeat edge %0d: got lvl=%b prs=%b rel=%b scn=%b, want lvl=%b prs=%b rel=%b scn=%b",
                 e, btn_level, btn_press, btn_release, btn_scen, e_lvl, e_prs, e_rel, e_scn);
      end
    end
  endtask

  task automatic test_release_bounce();
    do_reset();
    for (int e = 0; e < 26; e++) begin
      btn_raw = ((e == 9) || (e == 10)) ? 5'b00000 : 5'b01000;
      tick();
      // repeat counter reaches 5 by edge 10, frozen through edges 11-13
      // (RELEASE_WAIT and the return to HELD), then hits 7 at edge 16
      e_lvl = (e >= 5) ? 5'b01000 : 5'b00000;
      e_prs = (e == 5) ? 5'b01000 : 5'b00000;
      e_rel = '0;
      e_scn = ((e == 5) || (e == 16) || (e == 19) || (e == 22) || (e == 25))
              ? 5'b01000 : 5'b00000;
      vec_cnt++;
      if ({btn_level, btn_press, btn_release, btn_scen} !== {e_lvl, e_prs, e_rel, e_scn}) begin
        miss_cnt++;
        $display("FAIL release_bounce edge %0d: got lvl=%b prs=%b rel=%b scn=%b, want lvl=%b prs=%b rel=%b scn=%b",
                 e, btn_level, btn_press, btn_release, btn_scen, e_lvl, e_prs, e_rel, e_scn);
      end
    end
  endtask

  task automatic test_simultaneous_reset();
    do_reset();
    for (int e = 0; e < 17; e++) begin
      rst     = (e == 8);
      btn_raw = (e < 8) ? 5'b11111 : 5'b00000;
      tick();
      e_lvl = ((e >= 5) && (e < 8)) ? 5'b11111 : 5'b00000;
      e_prs = (e == 5) ? 5'b11111 : 5'b00000;
      e_rel = '0;
      e_scn = e_prs;
      vec_cnt++;
      if ({btn_level, btn_press, btn_release, btn_scen} !== {e_lvl, e_prs, e_rel, e_scn}) begin
        miss_cnt++;
        $display("FAIL simultaneous_reset edge %0d: got lvl=%b prs=%b rel=%b scn=%b, want lvl=%b prs=%b rel=%b scn=%b",
                 e, btn_level, btn_press, btn_release, btn_scen, e_lvl, e_prs, e_rel, e_scn);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    btn_raw = '0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_hold_repeat();
    test_release_bounce();
    test_simultaneous_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
